// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MIPS MEM stage.
// The control decoder and the data memory sequencer both use these:
//   - width codes for the 2-bit width field
//   - sign-flag values (0 signed, 1 unsigned)
//   - sequencer FSM state encoding
//   - helpers for the byte count and the alignment rule of a width code
package mips_mem_pkg;

  localparam logic [1:0] WIDTH_BYTE = 2'b00;
  localparam logic [1:0] WIDTH_HALF = 2'b01;
  localparam logic [1:0] WIDTH_WORD = 2'b10;
  localparam logic [1:0] WIDTH_NONE = 2'b11;

  localparam logic SIGN_SIGNED   = 1'b0;
  localparam logic SIGN_UNSIGNED = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } mem_state_e;

  // Number of SRAM byte cycles for a width code (0 for WIDTH_NONE).
  function automatic logic [2:0] byte_count(input logic [1:0] width);
    case (width)
      WIDTH_BYTE: byte_count = 3'd1;
      WIDTH_HALF: byte_count = 3'd2;
      WIDTH_WORD: byte_count = 3'd4;
      default:    byte_count = 3'd0;
    endcase
  endfunction

  // Natural alignment: halves on even addresses, words on multiples of 4.
  function automatic logic is_aligned(input logic [1:0] width, input logic [1:0] addr_lo);
    case (width)
      WIDTH_HALF: is_aligned = (addr_lo[0] == 1'b0);
      WIDTH_WORD: is_aligned = (addr_lo == 2'b00);
      default:    is_aligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/load_extender.sv
// Combinational load-result extension.
// Ports:
//   i_buf     32-bit little-endian byte buffer assembled from the SRAM
//   i_width   width code (byte / half / word)
//   i_sign    0 = sign-extend, 1 = zero-extend
//   o_result  extended 32-bit load value
// Word loads (and the unused NONE code) pass the buffer through unchanged.
module load_extender
  import mips_mem_pkg::*;
(
  input  logic [31:0] i_buf,
  input  logic [1:0]  i_width,
  input  logic        i_sign,
  output logic [31:0] o_result
);

  always_comb begin
    o_result = i_buf;
    case (i_width)
      WIDTH_BYTE: begin
        if (i_sign == SIGN_UNSIGNED) o_result = {24'h000000, i_buf[7:0]};
        else                         o_result = {{24{i_buf[7]}}, i_buf[7:0]};
      end
      WIDTH_HALF: begin
        if (i_sign == SIGN_UNSIGNED) o_result = {16'h0000, i_buf[15:0]};
        else                         o_result = {{16{i_buf[15]}}, i_buf[15:0]};
      end
      default: o_result = i_buf;
    endcase
  end

endmodule

// File: rtl/data_mem_sequencer.sv
// MEM-stage load/store engine in front of a byte-wide synchronous SRAM.
// A load or store of 1, 2 or 4 bytes is serialized into little-endian byte
// cycles; loads are extended to 32 bits; the pipeline is stalled meanwhile.
// Ports:
//   i_clk, i_rst_n           clock, asynchronous active-low reset
//   i_req                    MEM stage holds a valid instruction
//   i_memRead / i_memWrite   load / store request (exactly one must be set)
//   i_width, i_sign_flag     width code, 0 signed / 1 unsigned
//   i_addr, i_wdata          byte address, store data
//   o_stall                  freeze IF..MEM (accept | ISSUE | DRAIN)
//   o_done, o_misaligned     completion pulse and its misaligned qualifier
//   o_rdata                  extended load result, valid with o_done
//   o_mem_en/we/addr/wdata   registered SRAM command
//   i_mem_rdata              SRAM read byte, one cycle after a read command
//   o_dbg_state              current FSM state
// Handshake: a request is taken only in IDLE when i_req is high with exactly
// one of read/write set and a real width; its fields are sampled in that
// accept cycle only, and the requester keeps them stable while o_stall=1.
// o_done is a single-cycle pulse in DONE, where o_stall is already low so the
// pipeline advances in the same cycle it consumes o_rdata.
module data_mem_sequencer
  import mips_mem_pkg::*;
#(
  parameter int NB_DATA  = 32,
  parameter int NB_ADDR  = 10,
  parameter int NB_WIDTH = 2
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_req,
  input  logic                i_memRead,
  input  logic                i_memWrite,
  input  logic [NB_WIDTH-1:0] i_width,
  input  logic                i_sign_flag,
  input  logic [NB_ADDR-1:0]  i_addr,
  input  logic [NB_DATA-1:0]  i_wdata,
  output logic                o_stall,
  output logic                o_done,
  output logic [NB_DATA-1:0]  o_rdata,
  output logic                o_misaligned,
  output logic                o_mem_en,
  output logic                o_mem_we,
  output logic [NB_ADDR-1:0]  o_mem_addr,
  output logic [7:0]          o_mem_wdata,
  input  logic [7:0]          i_mem_rdata,
  output logic [1:0]          o_dbg_state
);

  mem_state_e          r_state;
  logic                r_is_load;
  logic                r_sign;
  logic [1:0]          r_width;
  logic [NB_ADDR-1:0]  r_addr;
  logic [NB_DATA-1:0]  r_wdata;
  logic [1:0]          r_k;        // byte index currently on the SRAM port
  logic [1:0]          r_last;     // index of the final byte (N-1)
  logic                r_cap_en;   // a read byte arrives on i_mem_rdata this cycle
  logic [1:0]          r_cap_idx;  // buffer slot for that byte
  logic [31:0]         r_buf;
  logic                r_done;
  logic                r_misaligned;
  logic [NB_DATA-1:0]  r_rdata;
  logic                r_mem_en;
  logic                r_mem_we;
  logic [NB_ADDR-1:0]  r_mem_addr;
  logic [7:0]          r_mem_wdata;

  logic                w_accept;
  logic                w_aligned;
  logic [1:0]          w_next_k;
  logic [NB_ADDR-1:0]  w_next_addr;
  logic [7:0]          w_next_wbyte;
  logic [31:0]         w_buf_next;
  logic [31:0]         w_ext;

  // Gated by reset so every output, including the combinational stall,
  // reads zero while reset is held.
  assign w_accept = i_rst_n & (r_state == ST_IDLE) & i_req &
                    (i_memRead ^ i_memWrite) & (i_width != WIDTH_NONE);
  assign w_aligned = is_aligned(i_width, i_addr[1:0]);

  assign w_next_k     = r_k + 2'd1;
  assign w_next_addr  = r_addr + {{(NB_ADDR-2){1'b0}}, w_next_k};
  assign w_next_wbyte = r_wdata[8*w_next_k +: 8];

  // Buffer including the byte arriving this cycle; DRAIN extends from this
  // view so the last byte does not need an extra register stage.
  always_comb begin
    w_buf_next = r_buf;
    if (r_cap_en) w_buf_next[8*r_cap_idx +: 8] = i_mem_rdata;
  end

  load_extender u_load_extender (
    .i_buf    (w_buf_next),
    .i_width  (r_width),
    .i_sign   (r_sign),
    .o_result (w_ext)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_is_load    <= 1'b0;
      r_sign       <= 1'b0;
      r_width      <= WIDTH_BYTE;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_k          <= 2'd0;
      r_last       <= 2'd0;
      r_cap_en     <= 1'b0;
      r_cap_idx    <= 2'd0;
      r_buf        <= 32'h0;
      r_done       <= 1'b0;
      r_misaligned <= 1'b0;
      r_rdata      <= '0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= 8'h00;
    end else begin
      r_done       <= 1'b0;
      r_misaligned <= 1'b0;
      r_cap_en     <= 1'b0;
      r_buf        <= w_buf_next;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_is_load <= i_memRead;
            r_sign    <= i_sign_flag;
            r_width   <= i_width;
            r_addr    <= i_addr;
            r_wdata   <= i_wdata;
            r_k       <= 2'd0;
            r_last    <= 2'(byte_count(i_width) - 3'd1);
            r_buf     <= 32'h0;
            if (!w_aligned) begin
              // Rejected without touching the SRAM.
              r_state      <= ST_DONE;
              r_done       <= 1'b1;
              r_misaligned <= 1'b1;
              r_rdata      <= '0;
            end else begin
              r_state     <= ST_ISSUE;
              r_mem_en    <= 1'b1;
              r_mem_we    <= i_memWrite;
              r_mem_addr  <= i_addr;
              r_mem_wdata <= i_wdata[7:0];
            end
          end
        end
        ST_ISSUE: begin
          // The byte read in this cycle is returned by the SRAM next cycle.
          r_cap_en  <= r_is_load;
          r_cap_idx <= r_k;
          if (r_k == r_last) begin
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
            if (r_is_load) begin
              r_state <= ST_DRAIN;
            end else begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end else begin
            r_k         <= w_next_k;
            r_mem_addr  <= w_next_addr;
            r_mem_wdata <= w_next_wbyte;
          end
        end
        ST_DRAIN: begin
          r_state <= ST_DONE;
          r_done  <= 1'b1;
          r_rdata <= w_ext;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_stall      = w_accept | (r_state == ST_ISSUE) | (r_state == ST_DRAIN);
  assign o_done       = r_done;
  assign o_misaligned = r_misaligned;
  assign o_rdata      = r_rdata;
  assign o_mem_en     = r_mem_en;
  assign o_mem_we     = r_mem_we;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wdata  = r_mem_wdata;
  assign o_dbg_state  = r_state;

endmodule
